// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared constants and helpers for the RAM arbiter slice.
//   - byte offset width used to turn byte addresses into word addresses
//   - requester port indices (fetch = 0, load/store = 1)
//   - byte-enable to active-low bit-write-mask expansion
package ram_arbiter_pkg;

  localparam int unsigned BYTE_OFS_W = 3;
  localparam int unsigned WORD_MSB   = 31;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  // Expand 8 active-high byte enables into the RAM's 64 active-low bit enables.
  function automatic logic [63:0] be_to_bweb(input logic [7:0] be);
    logic [63:0] bweb;
    bweb = '1;
    for (int k = 0; k < 8; k++) begin
      bweb[8*k +: 8] = {8{~be[k]}};
    end
    return bweb;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester-side bus of the RAM arbiter.
//   if_*  instruction fetch port (read-only)
//   ls_*  load/store port (read/write with byte enables)
// Modports:
//   master - requester view (drives req/addr/we/be/wdata)
//   slave  - arbiter view (drives gnt/rvalid/rdata/err)
interface ram_arbiter_if;

  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [63:0] if_rdata_o;
  logic        if_err_o;

  logic        ls_req_i;
  logic        ls_we_i;
  logic [31:0] ls_addr_i;
  logic [7:0]  ls_be_i;
  logic [63:0] ls_wdata_i;
  logic        ls_gnt_o;
  logic        ls_rvalid_o;
  logic [63:0] ls_rdata_o;
  logic        ls_err_o;

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    output ls_req_i, ls_we_i, ls_addr_i, ls_be_i, ls_wdata_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o
  );

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_be_i, ls_wdata_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o
  );

endinterface

// File: rtl/ram_rr_arb2.sv
// ram_rr_arb2: 2-way round-robin arbiter with a priority flop.
//   clk, rst  clock, synchronous active-high reset
//   req[1:0]  requests (index = port)
//   gnt[1:0]  combinational one-hot grant; all zero while rst is high
// prio names the port that wins a tie; after any grant it moves to the
// port that lost (or did not ask), and it holds while idle.
module ram_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic       prio;
  logic [1:0] req_v;

  // Requests are ignored while reset is high so no grant can escape.
  assign req_v  = req & {2{~rst}};
  assign gnt[0] = req_v[0] & (~req_v[1] | (prio == 1'b0));
  assign gnt[1] = req_v[1] & (~req_v[0] | (prio == 1'b1));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (gnt[0]) begin
      prio <= 1'b1;
    end else if (gnt[1]) begin
      prio <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port 64-bit RAM between instruction fetch
// and load/store with round-robin arbitration and one outstanding access.
//   clk, rst     clock, synchronous active-high reset
//   bus          requester bus (ram_arbiter_if.slave)
//   ram_ceb_o    RAM chip enable, active low
//   ram_web_o    RAM write enable, active low
//   ram_bweb_o   RAM bit-write enables, active low
//   ram_addr_o   RAM word address
//   ram_wdata_o  RAM write data
//   ram_rdata_i  RAM read data, valid the cycle after the access
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int MEM_AW    = 12,
  parameter int MEM_DEPTH = 4096
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      bus,
  output logic              ram_ceb_o,
  output logic              ram_web_o,
  output logic [63:0]       ram_bweb_o,
  output logic [MEM_AW-1:0] ram_addr_o,
  output logic [63:0]       ram_wdata_o,
  input  logic [63:0]       ram_rdata_i
);

  logic [1:0]  gnt;
  logic        any_gnt;
  logic        gnt_ls;
  logic [31:0] sel_addr;
  logic [WORD_MSB-BYTE_OFS_W:0] word;
  logic        in_range;
  logic        do_write;

  logic        rsp_valid;
  logic        rsp_port;
  logic        rsp_err;
  logic        rsp_we;
  logic        rsp_live;
  logic        rdata_ok;

  // Byte-offset bits never reach the RAM.
  logic        unused_ofs_bits;
  assign unused_ofs_bits = ^{bus.if_addr_i[BYTE_OFS_W-1:0],
                             bus.ls_addr_i[BYTE_OFS_W-1:0]};

  ram_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bus.ls_req_i, bus.if_req_i}),
    .gnt (gnt)
  );

  assign bus.if_gnt_o = gnt[PORT_IF];
  assign bus.ls_gnt_o = gnt[PORT_LS];
  assign any_gnt      = |gnt;
  assign gnt_ls       = gnt[PORT_LS];

  // Address decode on the granted port.
  assign sel_addr = gnt_ls ? bus.ls_addr_i : bus.if_addr_i;
  assign word     = sel_addr[WORD_MSB:BYTE_OFS_W];
  assign in_range = (32'(word) < 32'(MEM_DEPTH));

  // An out-of-range access is granted and answered with an error, but the
  // RAM pins stay idle for it.
  assign do_write    = gnt_ls & bus.ls_we_i & in_range;
  assign ram_ceb_o   = ~(any_gnt & in_range);
  assign ram_web_o   = ~do_write;
  assign ram_bweb_o  = do_write ? be_to_bweb(bus.ls_be_i) : '1;
  assign ram_addr_o  = word[MEM_AW-1:0];
  assign ram_wdata_o = bus.ls_wdata_i;

  // One outstanding access: the response for grant N is presented in N+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_port  <= PORT_IF;
      rsp_err   <= 1'b0;
      rsp_we    <= 1'b0;
    end else begin
      rsp_valid <= any_gnt;
      rsp_port  <= gnt_ls ? PORT_LS : PORT_IF;
      rsp_err   <= ~in_range;
      rsp_we    <= gnt_ls & bus.ls_we_i;
    end
  end

  // Reset in the response cycle swallows the pending response.
  assign rsp_live = rsp_valid & ~rst;
  assign rdata_ok = rsp_live & ~rsp_err & ~rsp_we;

  assign bus.if_rvalid_o = rsp_live & (rsp_port == PORT_IF);
  assign bus.ls_rvalid_o = rsp_live & (rsp_port == PORT_LS);
  assign bus.if_err_o    = bus.if_rvalid_o & rsp_err;
  assign bus.ls_err_o    = bus.ls_rvalid_o & rsp_err;
  assign bus.if_rdata_o  = (rdata_ok && rsp_port == PORT_IF) ? ram_rdata_i : '0;
  assign bus.ls_rdata_o  = (rdata_ok && rsp_port == PORT_LS) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a
// behavioural single-port RAM (1-cycle registered read, active-low masks).
module tb_ram_arbiter;

  localparam int MEM_AW    = 12;
  localparam int MEM_DEPTH = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              ram_ceb, ram_web;
  logic [63:0]       ram_bweb, ram_wdata;
  logic [MEM_AW-1:0] ram_addr;
  logic [63:0]       ram_rdata;
  logic [63:0]       mem [MEM_DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  ram_arbiter_if bus ();

  ram_arbiter #(.MEM_AW(MEM_AW), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .ram_ceb_o   (ram_ceb),
    .ram_web_o   (ram_web),
    .ram_bweb_o  (ram_bweb),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model.
  always @(posedge clk) begin
    if (!ram_ceb) begin
      if (!ram_web) mem[ram_addr] <= (mem[ram_addr] & ram_bweb) | (ram_wdata & ~ram_bweb);
      else          ram_rdata     <= mem[ram_addr];
    end
  end

  function automatic logic [63:0] pattern(input int k);
    return 64'hC0DE_0000_0000_0000 | 64'(k);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic req, input logic [31:0] addr);
    bus.if_req_i  = req;
    bus.if_addr_i = addr;
  endtask

  task automatic set_ls(input logic req, input logic we, input logic [31:0] addr,
                        input logic [7:0] be, input logic [63:0] wdata);
    bus.ls_req_i   = req;
    bus.ls_we_i    = we;
    bus.ls_addr_i  = addr;
    bus.ls_be_i    = be;
    bus.ls_wdata_i = wdata;
  endtask

  initial begin
    for (int k = 0; k < MEM_DEPTH; k++) mem[k] = pattern(k);
    mem[2]    = '1;
    ram_rdata = '0;

    // Reset with both requests asserted: nothing may be granted.
    rst = 1'b1;
    set_if(1'b1, 32'h18);
    set_ls(1'b1, 1'b1, 32'h10, 8'hFF, 64'h0);
    @(negedge clk);
    check("rst_if_gnt", 64'(bus.if_gnt_o), 64'd0);
    check("rst_ls_gnt", 64'(bus.ls_gnt_o), 64'd0);
    check("rst_ceb", 64'(ram_ceb), 64'd1);
    check("rst_web", 64'(ram_web), 64'd1);
    check("rst_bweb", ram_bweb, '1);
    check("rst_rvalid", 64'({bus.if_rvalid_o, bus.ls_rvalid_o}), 64'd0);
    check("rst_err", 64'({bus.if_err_o, bus.ls_err_o}), 64'd0);

    // Single fetch of word 3.
    next_cycle();
    rst = 1'b0;
    set_if(1'b1, 32'h18);
    set_ls(1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
    @(negedge clk);
    check("f_if_gnt", 64'(bus.if_gnt_o), 64'd1);
    check("f_ls_gnt", 64'(bus.ls_gnt_o), 64'd0);
    check("f_ceb", 64'(ram_ceb), 64'd0);
    check("f_addr", 64'(ram_addr), 64'd3);
    next_cycle();
    set_if(1'b0, 32'h0);
    @(negedge clk);
    check("f_rvalid", 64'(bus.if_rvalid_o), 64'd1);
    check("f_rdata", bus.if_rdata_o, pattern(3));
    check("f_err", 64'(bus.if_err_o), 64'd0);
    check("f_ls_rvalid", 64'(bus.ls_rvalid_o), 64'd0);

    // Byte write of the low half of word 2, then read it back.
    next_cycle();
    set_ls(1'b1, 1'b1, 32'h10, 8'h0F, 64'h1122_3344_5566_7788);
    @(negedge clk);
    check("w_gnt", 64'(bus.ls_gnt_o), 64'd1);
    check("w_ceb", 64'(ram_ceb), 64'd0);
    check("w_web", 64'(ram_web), 64'd0);
    check("w_bweb", ram_bweb, 64'hFFFF_FFFF_0000_0000);
    check("w_addr", 64'(ram_addr), 64'd2);
    check("w_wdata", ram_wdata, 64'h1122_3344_5566_7788);
    next_cycle();
    set_ls(1'b1, 1'b0, 32'h10, 8'h00, 64'h0);
    @(negedge clk);
    check("w_rvalid", 64'(bus.ls_rvalid_o), 64'd1);
    check("w_rdata", bus.ls_rdata_o, 64'd0);
    check("r_gnt", 64'(bus.ls_gnt_o), 64'd1);
    check("r_web", 64'(ram_web), 64'd1);
    check("r_bweb", ram_bweb, '1);
    next_cycle();
    set_ls(1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
    @(negedge clk);
    check("r_rvalid", 64'(bus.ls_rvalid_o), 64'd1);
    check("r_rdata", bus.ls_rdata_o, 64'hFFFF_FFFF_5566_7788);

    // Out-of-range load: granted, RAM idle, error response with zero data.
    next_cycle();
    set_ls(1'b1, 1'b0, 32'(MEM_DEPTH * 8), 8'h00, 64'h0);
    @(negedge clk);
    check("oor_gnt", 64'(bus.ls_gnt_o), 64'd1);
    check("oor_ceb", 64'(ram_ceb), 64'd1);
    next_cycle();
    set_ls(1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
    @(negedge clk);
    check("oor_rvalid", 64'(bus.ls_rvalid_o), 64'd1);
    check("oor_err", 64'(bus.ls_err_o), 64'd1);
    check("oor_rdata", bus.ls_rdata_o, 64'd0);

    // Contention from reset: grants alternate starting with fetch.
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    set_if(1'b1, 32'h08);
    set_ls(1'b1, 1'b0, 32'h20, 8'h00, 64'h0);
    for (int i = 0; i < 6; i++) begin
      logic exp_if_rv, exp_ls_rv;
      exp_if_rv = (i > 0) && ((i - 1) % 2 == 0);
      exp_ls_rv = (i > 0) && ((i - 1) % 2 == 1);
      @(negedge clk);
      check($sformatf("c%0d_if_gnt", i), 64'(bus.if_gnt_o), 64'(i % 2 == 0));
      check($sformatf("c%0d_ls_gnt", i), 64'(bus.ls_gnt_o), 64'(i % 2 == 1));
      check($sformatf("c%0d_if_rv", i), 64'(bus.if_rvalid_o), 64'(exp_if_rv));
      check($sformatf("c%0d_ls_rv", i), 64'(bus.ls_rvalid_o), 64'(exp_ls_rv));
      check($sformatf("c%0d_both_rv", i), 64'(bus.if_rvalid_o & bus.ls_rvalid_o), 64'd0);
      check($sformatf("c%0d_if_rd", i), bus.if_rdata_o, exp_if_rv ? pattern(1) : 64'd0);
      check($sformatf("c%0d_ls_rd", i), bus.ls_rdata_o, exp_ls_rv ? pattern(4) : 64'd0);
      next_cycle();
    end

    // Reset in the response cycle of a fetch.
    set_ls(1'b0, 1'b0, 32'h20, 8'h00, 64'h0);
    @(negedge clk);
    check("mr_if_gnt", 64'(bus.if_gnt_o), 64'd1);
    next_cycle();
    rst = 1'b1;
    set_ls(1'b1, 1'b0, 32'h20, 8'h00, 64'h0);
    @(negedge clk);
    check("mr_if_rvalid", 64'(bus.if_rvalid_o), 64'd0);
    check("mr_gnt", 64'({bus.if_gnt_o, bus.ls_gnt_o}), 64'd0);
    check("mr_ceb", 64'(ram_ceb), 64'd1);
    check("mr_web", 64'(ram_web), 64'd1);
    check("mr_bweb", ram_bweb, '1);
    check("mr_rdata", bus.if_rdata_o, 64'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_if_gnt", 64'(bus.if_gnt_o), 64'd1);
    check("post_rst_ls_gnt", 64'(bus.ls_gnt_o), 64'd0);
    next_cycle();
    @(negedge clk);
    check("post_rst_ls_gnt2", 64'(bus.ls_gnt_o), 64'd1);
    check("post_rst_if_rv", 64'(bus.if_rvalid_o), 64'd1);
    next_cycle();
    @(negedge clk);
    check("post_rst_if_gnt3", 64'(bus.if_gnt_o), 64'd1);
    check("post_rst_ls_rv", 64'(bus.ls_rvalid_o), 64'd1);

    // Idle: RAM stays disabled, prio (now favouring ls) holds.
    next_cycle();
    set_if(1'b0, 32'h0);
    set_ls(1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
    @(negedge clk);
    check("idle0_if_rv", 64'(bus.if_rvalid_o), 64'd1);
    check("idle0_ceb", 64'(ram_ceb), 64'd1);
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("idle%0d_ceb", i + 1), 64'(ram_ceb), 64'd1);
      check($sformatf("idle%0d_rv", i + 1), 64'({bus.if_rvalid_o, bus.ls_rvalid_o}), 64'd0);
    end
    next_cycle();
    set_if(1'b1, 32'h0);
    set_ls(1'b1, 1'b0, 32'h0, 8'h00, 64'h0);
    @(negedge clk);
    check("idle_prio_ls_gnt", 64'(bus.ls_gnt_o), 64'd1);
    check("idle_prio_if_gnt", 64'(bus.if_gnt_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
